// File: rtl/i2c_slave_reg_ctrl_pkg.sv
// Shared encodings for the I2C slave register controller: slave core states,
// transaction phases and common constants.
package i2c_slave_reg_ctrl_pkg;

    localparam logic [2:0] I2C_ST_IDLE = 3'd0;
    localparam logic [2:0] I2C_ST_ADDR = 3'd1;
    localparam logic [2:0] I2C_ST_ACK  = 3'd2;
    localparam logic [2:0] I2C_ST_RX   = 3'd3;
    localparam logic [2:0] I2C_ST_TX   = 3'd4;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_PTR  = 2'd1,
        PH_WR   = 2'd2
    } phase_t;

    localparam logic [7:0] ZERO8 = 8'h00;

endpackage

// File: rtl/i2c_reg_bank.sv
// NREGS x 8 register bank: one synchronous write port, a combinational read
// port feeding the slave transmit path and a registered read port for the host.
module i2c_reg_bank
    import i2c_slave_reg_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = 4
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] tx_addr,
    output logic [7:0]    tx_data,
    input  logic          host_re,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata
);

    logic [7:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= ZERO8;
            end
            host_rdata <= ZERO8;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            // Host data holds its last value between reads.
            if (host_re) begin
                host_rdata <= regs[host_addr];
            end
        end
    end

    assign tx_data = regs[tx_addr];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-bank controller behind the I2C slave byte interface: pointer byte,
// auto-incrementing reads/writes, and a shared write port with the host.
//
// state   | meaning
// PH_IDLE | no transaction; received bytes are ignored
// PH_PTR  | address phase seen; next received byte loads the pointer
// PH_WR   | pointer loaded; received bytes write reg[ptr], ptr increments
module i2c_slave_reg_ctrl
    import i2c_slave_reg_ctrl_pkg::*;
#(
    parameter int               NREGS   = 16,
    parameter int               AW      = 4,
    parameter logic [NREGS-1:0] RO_MASK = '0
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    slv_rx_data,
    input  logic          slv_received,
    input  logic          slv_sended,
    input  logic          slv_addr_ph,
    input  logic          slv_bus_idle,
    output logic [7:0]    slv_tx_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_ack,
    output logic [7:0]    host_rdata,
    output logic          i2c_wr_stb,
    output logic [AW-1:0] i2c_wr_addr,
    output logic [AW-1:0] ptr
);

    phase_t        phase;
    logic          last_rx, last_tx, last_ap;
    logic          rx_ev, tx_ev, ap_ev;
    logic          i2c_we, host_go, host_wr, host_re;
    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [7:0]    bank_wdata;
    logic [7:0]    bank_tx;

    assign rx_ev = slv_received & ~last_rx;
    assign tx_ev = slv_sended & ~last_tx;
    assign ap_ev = slv_addr_ph & ~last_ap;

    // Bus idle and restart override byte handling, so a write is only real
    // when the FSM will actually act on the byte.
    assign i2c_we  = (phase == PH_WR) & rx_ev & ~RO_MASK[ptr] & ~slv_bus_idle & ~ap_ev;
    assign host_go = host_req & ~host_ack;
    assign host_wr = host_go & host_we & ~i2c_we;
    assign host_re = host_go & ~host_we;

    assign bank_we    = i2c_we | host_wr;
    assign bank_waddr = i2c_we ? ptr : host_addr;
    assign bank_wdata = i2c_we ? slv_rx_data : host_wdata;

    i2c_reg_bank #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .we         (bank_we),
        .waddr      (bank_waddr),
        .wdata      (bank_wdata),
        .tx_addr    (ptr),
        .tx_data    (bank_tx),
        .host_re    (host_re),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase       <= PH_IDLE;
            ptr         <= '0;
            slv_tx_data <= ZERO8;
            host_ack    <= 1'b0;
            i2c_wr_stb  <= 1'b0;
            i2c_wr_addr <= '0;
            last_rx     <= 1'b1;
            last_tx     <= 1'b1;
            last_ap     <= 1'b1;
        end else begin
            last_rx     <= slv_received;
            last_tx     <= slv_sended;
            last_ap     <= slv_addr_ph;
            slv_tx_data <= bank_tx;
            host_ack    <= host_re | host_wr;
            i2c_wr_stb  <= i2c_we;
            if (i2c_we) begin
                i2c_wr_addr <= ptr;
            end

            if (slv_bus_idle) begin
                phase <= PH_IDLE;
            end else if (ap_ev) begin
                phase <= PH_PTR;
            end else begin
                case (phase)
                    PH_PTR: begin
                        if (rx_ev) begin
                            ptr   <= slv_rx_data[AW-1:0];
                            phase <= PH_WR;
                        end else if (tx_ev) begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                    PH_WR: begin
                        // Read-only targets still advance the pointer.
                        if (rx_ev || tx_ev) begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Self-checking bench for i2c_slave_reg_ctrl: a scripted vector table plus
// hand-written collision and reset sequences.
module tb_i2c_slave_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] slv_rx_data = 8'h00;
    logic       slv_received = 1'b0;
    logic       slv_sended = 1'b0;
    logic       slv_addr_ph = 1'b0;
    logic       slv_bus_idle = 1'b0;
    logic [7:0] slv_tx_data;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_wdata = 8'h00;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       i2c_wr_stb;
    logic [3:0] i2c_wr_addr;
    logic [3:0] ptr;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int stb_base = 0;
    logic [3:0] stb_last = 4'h0;

    always #5 clk = ~clk;

    i2c_slave_reg_ctrl #(
        .NREGS   (16),
        .AW      (4),
        .RO_MASK (16'h0001)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .slv_rx_data  (slv_rx_data),
        .slv_received (slv_received),
        .slv_sended   (slv_sended),
        .slv_addr_ph  (slv_addr_ph),
        .slv_bus_idle (slv_bus_idle),
        .slv_tx_data  (slv_tx_data),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .i2c_wr_stb   (i2c_wr_stb),
        .i2c_wr_addr  (i2c_wr_addr),
        .ptr          (ptr)
    );

    always @(negedge clk) begin
        if (i2c_wr_stb) begin
            stb_cnt  <= stb_cnt + 1;
            stb_last <= i2c_wr_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef enum int {OP_AP, OP_RX, OP_TX, OP_IDLE, OP_HW, OP_HR, OP_PTR, OP_TXD, OP_STB} op_t;
    typedef struct {
        op_t        op;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input op_t op, input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s #%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic rx_byte(input logic [7:0] d);
        @(negedge clk);
        slv_rx_data = d;
        slv_received = 1'b1;
        repeat (3) @(negedge clk);
        slv_received = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tx_pulse();
        @(negedge clk);
        slv_sended = 1'b1;
        repeat (3) @(negedge clk);
        slv_sended = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ap_pulse();
        @(negedge clk);
        slv_addr_ph = 1'b1;
        repeat (2) @(negedge clk);
        slv_addr_ph = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_pulse();
        @(negedge clk);
        slv_bus_idle = 1'b1;
        repeat (2) @(negedge clk);
        slv_bus_idle = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        lat = 0; rd = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = i;
                rd = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;

        // reset garbage test, then I2C write
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'h03, 0);
        add(OP_RX,   0, 8'hAA, 0);
        add(OP_STB,  3, 0,     1);
        add(OP_RX,   0, 8'hBB, 0);
        add(OP_STB,  4, 0,     1);
        add(OP_PTR,  0, 0,     8'h05);
        add(OP_HR,   3, 0,     8'hAA);
        add(OP_HR,   4, 0,     8'hBB);
        // pointer write, restart, read
        add(OP_IDLE, 0, 0,     0);
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'h03, 0);
        add(OP_AP,   0, 0,     0);
        add(OP_TXD,  0, 0,     8'hAA);
        add(OP_TX,   0, 0,     0);
        add(OP_TXD,  0, 0,     8'hBB);
        add(OP_TX,   0, 0,     0);
        add(OP_TXD,  0, 0,     8'h00);
        add(OP_TX,   0, 0,     0);
        add(OP_PTR,  0, 0,     8'h06);
        add(OP_STB,  0, 0,     0);
        // write wrap with read-only reg0
        add(OP_IDLE, 0, 0,     0);
        add(OP_HW,   0, 8'h5A, 0);
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'h0F, 0);
        add(OP_RX,   0, 8'h11, 0);
        add(OP_RX,   0, 8'h22, 0);
        add(OP_STB,  15, 0,    1);
        add(OP_PTR,  0, 0,     8'h01);
        add(OP_HR,   15, 0,    8'h11);
        add(OP_HR,   0, 0,     8'h5A);
        // read wrap
        add(OP_IDLE, 0, 0,     0);
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'h0F, 0);
        add(OP_AP,   0, 0,     0);
        add(OP_TXD,  0, 0,     8'h11);
        add(OP_TX,   0, 0,     0);
        add(OP_TXD,  0, 0,     8'h5A);
        add(OP_PTR,  0, 0,     8'h00);
        // upper pointer bits ignored
        add(OP_IDLE, 0, 0,     0);
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'hE3, 0);
        add(OP_PTR,  0, 0,     8'h03);
        add(OP_STB,  0, 0,     0);
        // abort by bus idle, stray byte ignored
        add(OP_IDLE, 0, 0,     0);
        add(OP_AP,   0, 0,     0);
        add(OP_RX,   0, 8'h06, 0);
        add(OP_RX,   0, 8'h77, 0);
        add(OP_STB,  6, 0,     1);
        add(OP_IDLE, 0, 0,     0);
        add(OP_RX,   0, 8'h99, 0);
        add(OP_STB,  0, 0,     0);
        add(OP_PTR,  0, 0,     8'h07);
        add(OP_HR,   6, 0,     8'h77);
        add(OP_HR,   7, 0,     8'h00);

        // Reset with garbage on the slave lines.
        slv_rx_data = 8'hFF; slv_received = 1'b1; slv_sended = 1'b1; slv_addr_ph = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stb_base = stb_cnt;
        check("rst_ptr",     0, ptr,         0);
        check("rst_txd",     0, slv_tx_data, 0);
        check("rst_ack",     0, host_ack,    0);
        check("rst_rdata",   0, host_rdata,  0);
        check("rst_stb",     0, i2c_wr_stb,  0);
        check("rst_wr_addr", 0, i2c_wr_addr, 0);
        repeat (3) @(negedge clk);
        slv_received = 1'b0; slv_sended = 1'b0; slv_addr_ph = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_edge_ptr", 0, ptr, 0);
        rx_byte(8'h05);
        check("rst_idle_ptr", 0, ptr, 0);
        check("rst_idle_stb", 0, stb_cnt - stb_base, 0);
        stb_base = stb_cnt;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_AP:   ap_pulse();
                OP_RX:   rx_byte(vecs[i].data);
                OP_TX:   tx_pulse();
                OP_IDLE: idle_pulse();
                OP_HW: begin
                    host_op(1'b1, vecs[i].addr, vecs[i].data, lat, rd);
                    check("hw_lat", i, lat, 1);
                end
                OP_HR: begin
                    host_op(1'b0, vecs[i].addr, 8'h00, lat, rd);
                    check("hr_lat", i, lat, 1);
                    check("hr_data", i, rd, vecs[i].exp);
                end
                OP_PTR: check("ptr", i, ptr, vecs[i].exp);
                OP_TXD: check("tx_data", i, slv_tx_data, vecs[i].exp);
                OP_STB: begin
                    check("stb_cnt", i, stb_cnt - stb_base, vecs[i].exp);
                    if (vecs[i].exp != 0) check("stb_addr", i, stb_last, vecs[i].addr);
                    stb_base = stb_cnt;
                end
                default: ;
            endcase
        end

        // Collision: I2C write of reg2 and host write of reg2 in the same cycle.
        idle_pulse();
        ap_pulse();
        rx_byte(8'h02);
        stb_base = stb_cnt;
        @(negedge clk);
        slv_rx_data = 8'h55; slv_received = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'h2; host_wdata = 8'h66;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = i;
                break;
            end
        end
        host_req = 1'b0;
        slv_received = 1'b0;
        repeat (2) @(negedge clk);
        check("coll_lat", 0, lat, 2);
        check("coll_stb_cnt", 0, stb_cnt - stb_base, 1);
        check("coll_stb_addr", 0, stb_last, 2);
        check("coll_ptr", 0, ptr, 3);
        host_op(1'b0, 4'h2, 8'h00, lat, rd);
        check("coll_data", 0, rd, 8'h66);

        // Reset while in the write phase.
        idle_pulse();
        ap_pulse();
        rx_byte(8'h09);
        rx_byte(8'h12);
        check("wr_ptr_pre_rst", 0, ptr, 4'hA);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_ptr", 0, ptr, 0);
        check("mid_rst_txd", 0, slv_tx_data, 0);
        stb_base = stb_cnt;
        rx_byte(8'h34);
        check("mid_rst_stb", 0, stb_cnt - stb_base, 0);
        check("mid_rst_ptr2", 0, ptr, 0);
        host_op(1'b0, 4'h9, 8'h00, lat, rd);
        check("mid_rst_reg9", 0, rd, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
